// File: rtl/icache_axi_refill_master.sv
// AXI4 read-burst initiator that refills one icache line per request.
// Optional critical-word-first WRAP mode: define ICACHE_REFILL_WRAP_EN.
module icache_axi_refill_master #(
  parameter int unsigned LINE_BEATS = 4,
  parameter logic [3:0]  ARID_VAL   = 4'd0
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [LINE_BEATS*64-1:0] resp_line,
  output logic                     resp_err,
`ifdef ICACHE_REFILL_WRAP_EN
  output logic                     crit_valid,
  output logic [63:0]              crit_data,
`endif
  output logic [31:0]              m_araddr,
  output logic [1:0]               m_arburst,
  output logic [3:0]               m_arcache,
  output logic [3:0]               m_arid,
  output logic [7:0]               m_arlen,
  output logic                     m_arlock,
  output logic [2:0]               m_arprot,
  input  logic                     m_arready,
  output logic [2:0]               m_arsize,
  output logic                     m_arvalid,
  input  logic [63:0]              m_rdata,
  input  logic [3:0]               m_rid,
  input  logic                     m_rlast,
  output logic                     m_rready,
  input  logic [1:0]               m_rresp,
  input  logic                     m_rvalid
);

  localparam int unsigned     OFFW      = $clog2(LINE_BEATS * 8);
  localparam int unsigned     IDXW      = $clog2(LINE_BEATS);
  localparam logic [IDXW-1:0] LAST_BEAT = IDXW'(LINE_BEATS - 1);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_t;

  state_t                         r_state, w_state_nxt;
  logic [31:0]                    r_araddr;
  logic [IDXW-1:0]                r_idx;
  logic [IDXW-1:0]                r_cnt;
  logic [LINE_BEATS-1:0][63:0]    r_line;
  logic                           r_err;
  logic                           w_req_fire;
  logic                           w_beat;
  logic                           w_beat_bad;
  logic                           w_resp_fire;
  logic [31:0]                    w_araddr;
  logic [IDXW-1:0]                w_start;

`ifdef ICACHE_REFILL_WRAP_EN
  logic        r_crit_valid;
  logic [63:0] r_crit_data;

  assign w_araddr   = {req_addr[31:3], 3'b000};
  assign w_start    = req_addr[OFFW-1:3];
  assign m_arburst  = 2'b10;
  assign crit_valid = r_crit_valid;
  assign crit_data  = r_crit_data;
`else
  assign w_araddr   = {req_addr[31:OFFW], {OFFW{1'b0}}};
  assign w_start    = '0;
  assign m_arburst  = 2'b01;
`endif

  assign w_req_fire  = (r_state == S_IDLE) && req_valid;
  assign w_beat      = (r_state == S_R) && m_rvalid;
  assign w_beat_bad  = (m_rresp != 2'b00) || (m_rid != ARID_VAL);
  assign w_resp_fire = (r_state == S_DONE) && resp_ready;

  assign req_ready  = (r_state == S_IDLE);
  assign m_arvalid  = (r_state == S_AR);
  assign m_rready   = (r_state == S_R);
  assign resp_valid = (r_state == S_DONE);
  assign resp_line  = r_line;
  assign resp_err   = r_err;
  assign m_araddr   = r_araddr;
  assign m_arlen    = 8'(LINE_BEATS - 1);
  assign m_arcache  = 4'b0000;
  assign m_arid     = ARID_VAL;
  assign m_arlock   = 1'b0;
  assign m_arprot   = 3'b100;
  assign m_arsize   = 3'b011;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // A burst ends on RLAST or on the final expected beat, whichever comes first.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (req_valid) w_state_nxt = S_AR;
      S_AR:    if (m_arready) w_state_nxt = S_R;
      S_R:     if (m_rvalid && (m_rlast || (r_cnt == LAST_BEAT))) w_state_nxt = S_DONE;
      S_DONE:  if (resp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_araddr <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_line   <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_req_fire) begin
        r_araddr <= w_araddr;
        r_idx    <= w_start;
        r_cnt    <= '0;
      end
      if (w_beat) begin
        r_line[r_idx] <= m_rdata;
        r_idx         <= r_idx + 1'b1;
        r_cnt         <= r_cnt + 1'b1;
        // RLAST must coincide exactly with the final beat; either mismatch is an error.
        if (w_beat_bad || (m_rlast != (r_cnt == LAST_BEAT))) r_err <= 1'b1;
      end
      if (w_resp_fire) r_err <= 1'b0;
    end
  end

`ifdef ICACHE_REFILL_WRAP_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_crit_valid <= 1'b0;
      r_crit_data  <= '0;
    end else begin
      r_crit_valid <= w_beat && (r_cnt == '0);
      if (w_beat && (r_cnt == '0)) r_crit_data <= m_rdata;
    end
  end
`endif

endmodule
